btb_predictor: RTL and testbench
================================

Name: btb_predictor

Overview:
- Branch Target Buffer with a 2-bit saturating direction predictor per entry.
- Sits in the IF stage. The combinational lookup on PCF produces the predicted next PC and a hit flag. These travel down the pipe as PPCD/BTBD into the ID-EX segment register.
- Updated from the EX stage using the resolved branch outcome.
- Also flags mispredictions, supplies the corrective PC, and keeps wrap-around branch/miss statistics.

Parameters:
- ENTRY_BITS, 6, log2 of entry count (64 entries, direct-mapped); index = PC[ENTRY_BITS+1:2].
- TAG_BITS, 30-ENTRY_BITS, tag = PC[31:ENTRY_BITS+2].
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- PCF  in  32  fetch PC.
- BTBF  out  1  predict-taken flag (entry hit AND counter[1]); travels as BTBD/BTBE.
- PPCF  out  32  predicted next PC; travels as PPCD/PPCE.
- en  in  1  EX-stage advance enable (same as ID-EX register en).
- UpdateE  in  1  EX holds a valid conditional branch (not a bubble).
- PCE  in  32  PC of EX instruction.
- BrE  in  1  resolved taken.
- BrTargetE  in  32  resolved target.
- BTBE  in  1  prediction carried with the instruction.
- PPCE  in  32  predicted PC carried with the instruction.
- MispredE  out  1  misprediction; drives IF/ID flush.
- RedirectPC  out  32  corrective fetch PC.
- BrCount  out  STAT_W  updated-branch count.
- MissCount  out  STAT_W  misprediction count.

Behaviour:
- Entry state: valid, tag[TAG_BITS], target[32], ctr[2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational, same cycle as PCF):
  - hitF = valid[idxF] & (tag[idxF]==tagF).
  - BTBF = hitF & ctr[idxF][1].
  - PPCF = BTBF ? target[idxF] : PCF+4, with 32-bit wrap.
- Misprediction (combinational):
  - MispredE = UpdateE & ((BrE != BTBE) | (BrE & BTBE & (PPCE != BrTargetE))).
  - RedirectPC = BrE ? BrTargetE : PCE+4.
  - MispredE is not gated by en.
- Update on the rising edge when rst_n=1 & en=1 & UpdateE=1:
  - Entry hit for PCE, taken: ctr saturates upward (11 stays 11); target <= BrTargetE.
  - Entry hit for PCE, not taken: ctr saturates downward (00 stays 00); target unchanged.
  - Miss (invalid or tag mismatch), BrE=1: allocate or replace. valid<=1, tag<=tagE, target<=BrTargetE, ctr<=10.
  - Miss, BrE=0: no table change.
  - BrCount increments by 1.
  - MissCount increments by 1 iff MispredE.
  - Both counters wrap modulo 2^STAT_W.
- Update gating:
  - en=0 (stall) or UpdateE=0: table and counters hold.
  - This guarantees exactly one update per branch even when EX is held across stall cycles.
- Same cycle, same index on lookup and update: the lookup returns the pre-update contents. The new value is visible from the next cycle.
- Reset (rst_n=0 at an edge):
  - All valid bits <= 0, all ctr <= 00, BrCount <= 0, MissCount <= 0.
  - Target/tag arrays may keep stale data; valid=0 masks it.
  - Reset has priority over an update in the same cycle.
- Outputs after reset: BTBF=0 and PPCF=PCF+4 for every PCF. MispredE/RedirectPC follow their inputs combinationally.
- Reset asserted mid-operation discards any pending update. No partial entry writes.

Test Plan:
- Cold table, after reset: PCF=0x0000_0100 -> BTBF=0, PPCF=0x0000_0104. BrCount=MissCount=0.
- Allocation and hit:
  - Stimulus: UpdateE=1, en=1, PCE=0x100, BrE=1, BrTargetE=0x200, BTBE=0, PPCE=0x104.
  - Same cycle: MispredE=1, RedirectPC=0x200.
  - Next cycle: PCF=0x100 gives BTBF=1, PPCF=0x200; MissCount=1.
- Counter saturation and not-taken path on the 0x100 entry:
  - Two further taken updates -> ctr=11.
  - Three not-taken updates -> ctr=00; PCF=0x100 then gives BTBF=0, PPCF=0x104.
  - Not-taken update with BTBE=1 -> MispredE=1, RedirectPC=0x104.
  - An extra not-taken update leaves ctr=00.
- Aliasing: PCE=0x100 and PCE=0x100+(4<<ENTRY_BITS)=0x200 share index 0.
  - Taken update of 0x200 (target 0x400) replaces the entry.
  - PCF=0x100 now misses (BTBF=0); PCF=0x200 gives PPCF=0x400.
- Stall and wrong target:
  - UpdateE=1 held for 3 cycles with en=0 then 1 cycle with en=1 -> BrCount increments exactly once.
  - BTBE=1, BrE=1, PPCE=0x300, BrTargetE=0x200 -> MispredE=1, stored target becomes 0x200.
- Reset priority and read-before-write:
  - rst_n=0 in the same cycle as a taken update -> entry stays invalid, counters stay 0.
  - Lookup and update on the same index in one cycle -> the lookup shows the old value and the new value appears the next cycle.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Fetch lookup is combinational; training happens at the EX stage.
module btb_predictor #(
    parameter int ENTRY_BITS = 6,
    parameter int TAG_BITS   = 30 - ENTRY_BITS,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       PCF,
    output logic              BTBF,
    output logic [31:0]       PPCF,
    input  logic              en,
    input  logic              UpdateE,
    input  logic [31:0]       PCE,
    input  logic              BrE,
    input  logic [31:0]       BrTargetE,
    input  logic              BTBE,
    input  logic [31:0]       PPCE,
    output logic              MispredE,
    output logic [31:0]       RedirectPC,
    output logic [STAT_W-1:0] BrCount,
    output logic [STAT_W-1:0] MissCount
);
    localparam int ENTRIES = 1 << ENTRY_BITS;

    logic                  valid_w    [ENTRIES];
    logic [1:0]            ctr_w      [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
    logic [31:0]           target_mem [ENTRIES];

    logic [ENTRY_BITS-1:0] idx_f;
    logic [TAG_BITS-1:0]   tag_f;
    logic                  hit_f;
    logic [ENTRY_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_e;
    logic [1:0]            ctr_e;
    logic [1:0]            ctr_next;
    logic                  upd_e;

    logic [STAT_W-1:0]     br_count_reg;
    logic [STAT_W-1:0]     miss_count_reg;

    assign idx_f = PCF[ENTRY_BITS+1:2];
    assign tag_f = PCF[31:ENTRY_BITS+2];
    assign hit_f = valid_w[idx_f] && (tag_mem[idx_f] == tag_f);
    assign BTBF  = hit_f && ctr_w[idx_f][1];
    assign PPCF  = BTBF ? target_mem[idx_f] : (PCF + 32'd4);

    assign MispredE   = UpdateE && ((BrE != BTBE) || (BrE && BTBE && (PPCE != BrTargetE)));
    assign RedirectPC = BrE ? BrTargetE : (PCE + 32'd4);

    assign idx_e = PCE[ENTRY_BITS+1:2];
    assign tag_e = PCE[31:ENTRY_BITS+2];
    assign hit_e = valid_w[idx_e] && (tag_mem[idx_e] == tag_e);
    assign ctr_e = ctr_w[idx_e];
    // A stalled EX stage holds its branch; only the advancing cycle may train.
    assign upd_e = en && UpdateE;

    always_comb begin
        ctr_next = ctr_e;
        if (BrE) begin
            if (ctr_e != 2'b11) ctr_next = ctr_e + 2'b01;
        end else begin
            if (ctr_e != 2'b00) ctr_next = ctr_e - 2'b01;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic       valid_reg;
            logic [1:0] ctr_reg;
            logic       sel;

            assign sel = upd_e && (idx_e == ENTRY_BITS'(gi));

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= 2'b00;
                end else if (sel) begin
                    if (hit_e) begin
                        ctr_reg <= ctr_next;
                    end else if (BrE) begin
                        valid_reg <= 1'b1;
                        ctr_reg   <= 2'b10;
                    end
                end
            end

            assign valid_w[gi] = valid_reg;
            assign ctr_w[gi]   = ctr_reg;
        end
    endgenerate

    // Tag rewrite on a hit is harmless (same tag); reset blocks any write.
    always_ff @(posedge clk) begin
        if (rst_n && upd_e && BrE) begin
            tag_mem[idx_e]    <= tag_e;
            target_mem[idx_e] <= BrTargetE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count_reg   <= '0;
            miss_count_reg <= '0;
        end else if (upd_e) begin
            br_count_reg <= br_count_reg + 1'b1;
            if (MispredE) miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

    assign BrCount   = br_count_reg;
    assign MissCount = miss_count_reg;
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: allocation, counter saturation, aliasing,
// stall gating, reset priority and same-cycle read-before-write.
module tb_btb_predictor;
    logic        clk;
    logic        rst_n;
    logic [31:0] PCF;
    logic        BTBF;
    logic [31:0] PPCF;
    logic        en;
    logic        UpdateE;
    logic [31:0] PCE;
    logic        BrE;
    logic [31:0] BrTargetE;
    logic        BTBE;
    logic [31:0] PPCE;
    logic        MispredE;
    logic [31:0] RedirectPC;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    int n_cmp;
    int n_err;
    int exp_br;
    int exp_miss;
    logic        mis_obs;
    logic [31:0] redir_obs;

    btb_predictor dut (
        .clk(clk), .rst_n(rst_n), .PCF(PCF), .BTBF(BTBF), .PPCF(PPCF),
        .en(en), .UpdateE(UpdateE), .PCE(PCE), .BrE(BrE), .BrTargetE(BrTargetE),
        .BTBE(BTBE), .PPCE(PPCE), .MispredE(MispredE), .RedirectPC(RedirectPC),
        .BrCount(BrCount), .MissCount(MissCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one EX branch for a single advancing cycle; records MispredE/RedirectPC before the edge.
    task automatic do_update(input logic [31:0] pce, input logic br, input logic [31:0] tgt,
                             input logic btbe, input logic [31:0] ppce);
        PCE = pce; BrE = br; BrTargetE = tgt; BTBE = btbe; PPCE = ppce;
        UpdateE = 1'b1; en = 1'b1;
        #1;
        mis_obs = MispredE;
        redir_obs = RedirectPC;
        tick();
        UpdateE = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        PCF = pc;
        #1;
    endtask

    task automatic test_reset();
        lookup(32'h0000_0100);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL reset_btbf: got %0h want 0", BTBF); end
        n_cmp++; if (PPCF !== 32'h104) begin n_err++; $display("FAIL reset_ppcf: got %08h want 00000104", PPCF); end
        n_cmp++; if (BrCount !== 32'd0) begin n_err++; $display("FAIL reset_brcount: got %0d want 0", BrCount); end
        n_cmp++; if (MissCount !== 32'd0) begin n_err++; $display("FAIL reset_misscount: got %0d want 0", MissCount); end
        lookup(32'hFFFF_FFFC);
        n_cmp++; if (PPCF !== 32'h0) begin n_err++; $display("FAIL reset_ppcf_wrap: got %08h want 00000000", PPCF); end
        n_cmp++; if (MispredE !== 1'b0) begin n_err++; $display("FAIL idle_mispred: got %0h want 0", MispredE); end
        $display("test_reset: BTBF=%0h PPCF=%08h BrCount=%0d MissCount=%0d", BTBF, PPCF, BrCount, MissCount);
    endtask

    task automatic test_alloc();
        PCF = 32'h100;
        do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        exp_br++; exp_miss++;
        n_cmp++; if (mis_obs !== 1'b1) begin n_err++; $display("FAIL alloc_mispred: got %0h want 1", mis_obs); end
        n_cmp++; if (redir_obs !== 32'h200) begin n_err++; $display("FAIL alloc_redirect: got %08h want 00000200", redir_obs); end
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b1) begin n_err++; $display("FAIL alloc_btbf: got %0h want 1", BTBF); end
        n_cmp++; if (PPCF !== 32'h200) begin n_err++; $display("FAIL alloc_ppcf: got %08h want 00000200", PPCF); end
        n_cmp++; if (MissCount !== 32'(exp_miss)) begin n_err++; $display("FAIL alloc_miss: got %0d want %0d", MissCount, exp_miss); end
        n_cmp++; if (BrCount !== 32'(exp_br)) begin n_err++; $display("FAIL alloc_br: got %0d want %0d", BrCount, exp_br); end
        $display("test_alloc: mispred=%0h redirect=%08h PPCF=%08h", mis_obs, redir_obs, PPCF);
    endtask

    task automatic test_saturation();
        // 10 -> 11 -> 11, correctly predicted
        do_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200); exp_br++;
        n_cmp++; if (mis_obs !== 1'b0) begin n_err++; $display("FAIL sat_t1_mispred: got %0h want 0", mis_obs); end
        do_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200); exp_br++;
        // 11 -> 10: still taken, target must not follow the not-taken BrTargetE
        do_update(32'h100, 1'b0, 32'h700, 1'b1, 32'h200); exp_br++; exp_miss++;
        n_cmp++; if (mis_obs !== 1'b1) begin n_err++; $display("FAIL sat_nt1_mispred: got %0h want 1", mis_obs); end
        n_cmp++; if (redir_obs !== 32'h104) begin n_err++; $display("FAIL sat_nt1_redirect: got %08h want 00000104", redir_obs); end
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b1) begin n_err++; $display("FAIL sat_nt1_btbf: got %0h want 1", BTBF); end
        n_cmp++; if (PPCF !== 32'h200) begin n_err++; $display("FAIL sat_nt1_ppcf: got %08h want 00000200", PPCF); end
        // 10 -> 01
        do_update(32'h100, 1'b0, 32'h700, 1'b1, 32'h200); exp_br++; exp_miss++;
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL sat_nt2_btbf: got %0h want 0", BTBF); end
        // 01 -> 00, 00 -> 00
        do_update(32'h100, 1'b0, 32'h700, 1'b0, 32'h104); exp_br++;
        n_cmp++; if (mis_obs !== 1'b0) begin n_err++; $display("FAIL sat_nt3_mispred: got %0h want 0", mis_obs); end
        lookup(32'h100);
        n_cmp++; if (PPCF !== 32'h104) begin n_err++; $display("FAIL sat_nt3_ppcf: got %08h want 00000104", PPCF); end
        do_update(32'h100, 1'b0, 32'h700, 1'b0, 32'h104); exp_br++;
        // From 00 one taken gives 01 (not taken yet), a second gives 10
        do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104); exp_br++; exp_miss++;
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL sat_floor_btbf: got %0h want 0", BTBF); end
        do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104); exp_br++; exp_miss++;
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b1) begin n_err++; $display("FAIL sat_climb_btbf: got %0h want 1", BTBF); end
        n_cmp++; if (BrCount !== 32'(exp_br)) begin n_err++; $display("FAIL sat_br: got %0d want %0d", BrCount, exp_br); end
        n_cmp++; if (MissCount !== 32'(exp_miss)) begin n_err++; $display("FAIL sat_miss: got %0d want %0d", MissCount, exp_miss); end
        $display("test_saturation: BrCount=%0d MissCount=%0d BTBF=%0h", BrCount, MissCount, BTBF);
    endtask

    task automatic test_alias();
        do_update(32'h200, 1'b1, 32'h400, 1'b0, 32'h204); exp_br++; exp_miss++;
        lookup(32'h100);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL alias_old_btbf: got %0h want 0", BTBF); end
        n_cmp++; if (PPCF !== 32'h104) begin n_err++; $display("FAIL alias_old_ppcf: got %08h want 00000104", PPCF); end
        lookup(32'h200);
        n_cmp++; if (BTBF !== 1'b1) begin n_err++; $display("FAIL alias_new_btbf: got %0h want 1", BTBF); end
        n_cmp++; if (PPCF !== 32'h400) begin n_err++; $display("FAIL alias_new_ppcf: got %08h want 00000400", PPCF); end
        $display("test_alias: PCF=00000200 BTBF=%0h PPCF=%08h", BTBF, PPCF);
    endtask

    task automatic test_stall();
        PCF = 32'h200;
        PCE = 32'h200; BrE = 1'b1; BrTargetE = 32'h200; BTBE = 1'b1; PPCE = 32'h300;
        UpdateE = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (MispredE !== 1'b1) begin n_err++; $display("FAIL stall_mispred[%0d]: got %0h want 1", i, MispredE); end
            tick();
            n_cmp++; if (BrCount !== 32'(exp_br)) begin n_err++; $display("FAIL stall_br[%0d]: got %0d want %0d", i, BrCount, exp_br); end
            n_cmp++; if (PPCF !== 32'h400) begin n_err++; $display("FAIL stall_ppcf[%0d]: got %08h want 00000400", i, PPCF); end
        end
        do_update(32'h200, 1'b1, 32'h200, 1'b1, 32'h300); exp_br++; exp_miss++;
        n_cmp++; if (redir_obs !== 32'h200) begin n_err++; $display("FAIL wrongtgt_redirect: got %08h want 00000200", redir_obs); end
        lookup(32'h200);
        n_cmp++; if (PPCF !== 32'h200) begin n_err++; $display("FAIL wrongtgt_ppcf: got %08h want 00000200", PPCF); end
        n_cmp++; if (BrCount !== 32'(exp_br)) begin n_err++; $display("FAIL stall_br_final: got %0d want %0d", BrCount, exp_br); end
        n_cmp++; if (MissCount !== 32'(exp_miss)) begin n_err++; $display("FAIL stall_miss_final: got %0d want %0d", MissCount, exp_miss); end
        $display("test_stall: BrCount=%0d MissCount=%0d PPCF=%08h", BrCount, MissCount, PPCF);
    endtask

    task automatic test_reset_priority();
        rst_n = 1'b0;
        do_update(32'h104, 1'b1, 32'h500, 1'b0, 32'h108);
        rst_n = 1'b1;
        exp_br = 0; exp_miss = 0;
        lookup(32'h104);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL rstpri_btbf: got %0h want 0", BTBF); end
        n_cmp++; if (PPCF !== 32'h108) begin n_err++; $display("FAIL rstpri_ppcf: got %08h want 00000108", PPCF); end
        lookup(32'h200);
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL rstpri_cleared: got %0h want 0", BTBF); end
        n_cmp++; if (BrCount !== 32'd0) begin n_err++; $display("FAIL rstpri_br: got %0d want 0", BrCount); end
        n_cmp++; if (MissCount !== 32'd0) begin n_err++; $display("FAIL rstpri_miss: got %0d want 0", MissCount); end
        $display("test_reset_priority: BTBF=%0h BrCount=%0d MissCount=%0d", BTBF, BrCount, MissCount);
    endtask

    task automatic test_back_to_back();
        PCF = 32'h104;
        PCE = 32'h104; BrE = 1'b1; BrTargetE = 32'h500; BTBE = 1'b0; PPCE = 32'h108;
        UpdateE = 1'b1; en = 1'b1;
        #1;
        n_cmp++; if (BTBF !== 1'b0) begin n_err++; $display("FAIL rbw_old_btbf: got %0h want 0", BTBF); end
        n_cmp++; if (PPCF !== 32'h108) begin n_err++; $display("FAIL rbw_old_ppcf: got %08h want 00000108", PPCF); end
        tick();
        // second branch on another index in the very next cycle
        PCE = 32'h108; BrE = 1'b1; BrTargetE = 32'h600; BTBE = 1'b0; PPCE = 32'h10C;
        #1;
        n_cmp++; if (BTBF !== 1'b1) begin n_err++; $display("FAIL rbw_new_btbf: got %0h want 1", BTBF); end
        n_cmp++; if (PPCF !== 32'h500) begin n_err++; $display("FAIL rbw_new_ppcf: got %08h want 00000500", PPCF); end
        tick();
        UpdateE = 1'b0;
        lookup(32'h108);
        n_cmp++; if (PPCF !== 32'h600) begin n_err++; $display("FAIL b2b_ppcf: got %08h want 00000600", PPCF); end
        n_cmp++; if (BrCount !== 32'd2) begin n_err++; $display("FAIL b2b_br: got %0d want 2", BrCount); end
        n_cmp++; if (MissCount !== 32'd2) begin n_err++; $display("FAIL b2b_miss: got %0d want 2", MissCount); end
        $display("test_back_to_back: PPCF=%08h BrCount=%0d MissCount=%0d", PPCF, BrCount, MissCount);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_br = 0; exp_miss = 0;
        mis_obs = 1'b0; redir_obs = 32'h0;
        rst_n = 1'b0; PCF = 32'h0; en = 1'b1; UpdateE = 1'b0;
        PCE = 32'h0; BrE = 1'b0; BrTargetE = 32'h0; BTBE = 1'b0; PPCE = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
        test_reset();
        test_alloc();
        test_saturation();
        test_alias();
        test_stall();
        test_reset_priority();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
